// File: rtl/serdes_pkg.sv
// Shared definitions for the serial shift-link blocks (transmitter and receivers).
package serdes_pkg;

  // Default number of data bits per frame, common to both ends of the link.
  localparam int DEFAULT_WIDTH = 4;

  // Transmitter FSM encoding.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register with a serial output tap. Zeros are shifted in, so
// the register drains to all-zero once a frame has been fully presented.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_sr;

  // Load has priority over shift; direction fixed by MSB_FIRST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift_en) begin
      if (MSB_FIRST) r_sr <= {r_sr[WIDTH-2:0], 1'b0};
      else           r_sr <= {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  assign o_sout = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load handshake.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pin,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = WIDTH + PAR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_frame_start;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_shift_en;
  logic [FRAME_W-1:0]     w_frame;

  // The parity bit sits after the data in transmit order, so its position in
  // the loaded word depends on which end is tapped.
`ifdef PISO_PARITY_EN
  assign w_frame = MSB_FIRST ? {pin, ^pin} : {^pin, pin};
`else
  assign w_frame = pin;
`endif

  assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_W'(FRAME_W));
  assign load_ready = rst_n && ((r_state == S_IDLE) || w_last);
  assign w_accept   = load_valid && load_ready;
  assign w_shift_en = (r_state == S_SHIFT) && !w_accept;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: a load accepted on the last bit keeps us in SHIFT with no gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bits already presented on dout; restarts at 1 with each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_accept)           r_cnt <= CNT_W'(1);
    else if (r_state == S_SHIFT) r_cnt <= r_cnt + CNT_W'(1);
    else                         r_cnt <= '0;
  end

  // First-bit marker, high for the cycle following an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_start <= 1'b0;
    else        r_frame_start <= w_accept;
  end

  piso_shift_reg #(
    .WIDTH     (FRAME_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_shift_en (w_shift_en),
    .i_din      (w_frame),
    .o_sout     (dout)
  );

  assign dout_valid  = (r_state == S_SHIFT);
  assign busy        = (r_state != S_IDLE);
  assign frame_start = r_frame_start;

endmodule
